wdata_handler_buf: RTL

Parametrised, buffered successor of the C-matrix write handler. It captures one result row per cycle from the systolic array for a burst of ROWS rows, with a runtime base address and stride. Rows go into an internal FIFO, and the FIFO drains to the memory write port under a grant handshake, so memory backpressure never stalls the array. It also reports burst completion, activity and sticky error conditions.

---
 rtl/wdata_handler_buf.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wdata_handler_buf.sv
// Buffered C-matrix write handler: captures a ROWS-row burst from the systolic array
// into a row FIFO and drains it to memory under a request/grant handshake.
module wdata_handler_buf #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [ADDR_W-1:0]        addr_c_i,
    input  logic [ADDR_W-1:0]        stride_i,
    input  logic [COLS*DATA_W-1:0]   c_i,
    output logic                     en_c_o,
    input  logic                     gnt_c_i,
    output logic [ADDR_W-1:0]        addr_c_o,
    output logic [COLS*DATA_W-1:0]   wdata_c_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic                     ovf_o,
    output logic                     proto_err_o
);
    localparam int RW = COLS * DATA_W;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, CAPTURE} state_t;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [RW-1:0]     data;
    } entry_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] stride_q;
    logic              push_req;
    entry_t            push_entry;

    entry_t            mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              empty, full, push, pop, drop;
    entry_t            head;

    // Capture FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i && (ROWS > 1)) state_nxt = CAPTURE;
            CAPTURE: if (cnt == CW'(1))         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture FSM: outputs (the row to push this cycle)
    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    push_req        = 1'b1;
                    push_entry.last = (ROWS == 1);
                    push_entry.addr = addr_c_i;
                    push_entry.data = c_i;
                end
            end
            CAPTURE: begin
                push_req        = 1'b1;
                push_entry.last = (cnt == CW'(1));
                push_entry.addr = cur_addr;
                push_entry.data = c_i;
            end
            default: ;
        endcase
    end

    // cur_addr already points at row 1 when the burst enters CAPTURE
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            cur_addr <= '0;
            stride_q <= '0;
        end else if (state == IDLE && valid_i) begin
            cnt      <= CW'(ROWS - 1);
            cur_addr <= addr_c_i + stride_i;
            stride_q <= stride_i;
        end else if (state == CAPTURE) begin
            cnt      <= cnt - CW'(1);
            cur_addr <= cur_addr + stride_q;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign pop   = !empty && gnt_c_i;
    // A full FIFO still takes a row when the head leaves in the same cycle
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ovf_o       <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            ovf_o       <= ovf_o | drop;
            proto_err_o <= proto_err_o | (state == CAPTURE && valid_i);
        end
    end

    assign en_c_o    = !empty;
    assign addr_c_o  = empty ? '0 : head.addr;
    assign wdata_c_o = empty ? '0 : head.data;
    assign done_o    = pop & head.last;
    assign busy_o    = (state == CAPTURE) | !empty;

endmodule
